// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshakes and status flags.
// Sits between the register file and the writeback stage of the datapath.
// Optional feature macro: ALU_MUL_EN -- when defined, opcode 111 runs a
// multi-cycle shift-add unsigned multiplier (BUSY state, counter, accumulator);
// when undefined, opcode 111 completes in one cycle with out=0 and err=1.

module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_v,
    output logic             err
);

    localparam int MSB = WIDTH - 1;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_t;
`endif

    state_t state;
    state_t next_state;
    state_t start_state;

    logic             accept;
    logic             ready_int;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic             res_err;
    logic [WIDTH:0]   sum;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               is_mul;
    logic               mul_last;

    assign is_mul   = (opc == 3'b111);
    assign mul_last = (cnt == CNT_W'(WIDTH));
`endif

    assign accept = in_valid && in_ready;

    // Single-cycle result and flag candidates for the operation on the inputs.
    always_comb begin
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_err = 1'b0;
        sum     = '0;
        case (opc)
            3'b000: res = ~(A & B);
            3'b001: res = ~(A | B);
            3'b010: res = A ^ B;
            3'b011: begin
                sum   = {1'b0, A} + {1'b0, B};
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (A[MSB] == B[MSB]) && (res[MSB] != A[MSB]);
            end
            3'b100: begin
                sum   = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (A[MSB] == ~B[MSB]) && (res[MSB] != A[MSB]);
            end
            3'b101: begin
                res   = {A[WIDTH-2:0], 1'b0};
                res_c = A[MSB];
            end
            3'b110: begin
                res   = {1'b0, A[WIDTH-1:1]};
                res_c = A[0];
            end
            default: begin
`ifdef ALU_MUL_EN
                res_err = 1'b0;
`else
                res_err = 1'b1;
`endif
            end
        endcase
    end

    // Where an accepted operation goes next: multiplies detour through BUSY.
    always_comb begin
`ifdef ALU_MUL_EN
        start_state = is_mul ? BUSY : DONE;
`else
        start_state = DONE;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic for the handshake FSM.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state = start_state;
                end
            end
`ifdef ALU_MUL_EN
            BUSY: begin
                if (mul_last) begin
                    next_state = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    next_state = in_valid ? start_state : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs; in_ready is held low while reset is asserted.
    always_comb begin
        ready_int = 1'b0;
        case (state)
            IDLE:    ready_int = 1'b1;
            DONE:    ready_int = out_ready;
            default: ready_int = 1'b0;
        endcase
        in_ready  = rst_n && ready_int;
        out_valid = (state == DONE);
    end

    // Result/flag registers and the shift-add multiplier datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out    <= '0;
            out_hi <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
            err    <= 1'b0;
`ifdef ALU_MUL_EN
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
`endif
        end else begin
`ifdef ALU_MUL_EN
            if (accept && is_mul) begin
                mcand  <= {{WIDTH{1'b0}}, A};
                mplier <= B;
                acc    <= '0;
                cnt    <= '0;
            end else if (accept) begin
                out    <= res;
                out_hi <= '0;
                flag_z <= (res == '0);
                flag_c <= res_c;
                flag_n <= res[MSB];
                flag_v <= res_v;
                err    <= res_err;
            end else if (state == BUSY) begin
                if (mul_last) begin
                    out    <= acc[WIDTH-1:0];
                    out_hi <= acc[2*WIDTH-1:WIDTH];
                    flag_z <= (acc[WIDTH-1:0] == '0);
                    flag_c <= 1'b0;
                    flag_n <= acc[WIDTH-1];
                    flag_v <= 1'b0;
                    err    <= 1'b0;
                end else begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
            end
`else
            if (accept) begin
                out    <= res;
                out_hi <= '0;
                flag_z <= (res == '0);
                flag_c <= res_c;
                flag_n <= res[MSB];
                flag_v <= res_v;
                err    <= res_err;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=8).
// Follows ALU_MUL_EN the same way as the design, so either build can be checked.

module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] opc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [7:0] out_hi;
    logic       flag_z;
    logic       flag_c;
    logic       flag_n;
    logic       flag_v;
    logic       err;

    int tests;
    int failures;

    localparam logic [2:0] OP_NAND = 3'b000;
    localparam logic [2:0] OP_NOR  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .opc       (opc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_hi    (out_hi),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_n    (flag_n),
        .flag_v    (flag_v),
        .err       (err)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_flags(input string tag, input logic [4:0] expected);
        check_output(tag, {11'd0, flag_z, flag_c, flag_n, flag_v, err}, {11'd0, expected});
    endtask

    task automatic apply_stimulus(input logic valid, input logic [2:0] op,
                                  input logic [7:0] a, input logic [7:0] b);
        in_valid = valid;
        opc      = op;
        A        = a;
        B        = b;
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests     = 0;
        failures  = 0;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        apply_stimulus(1'b0, OP_NAND, 8'h00, 8'h00);

        // Reset state.
        #12;
        check_output("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check_output("rst_in_ready", {15'd0, in_ready}, 16'd0);
        check_output("rst_out", {out_hi, out}, 16'h0000);
        check_flags("rst_flags", 5'b00000);
        rst_n = 1'b1;
        #1;
        check_output("idle_in_ready", {15'd0, in_ready}, 16'd1);

        // ADD FF+01: wraps to zero with carry.
        out_ready = 1'b1;
        apply_stimulus(1'b1, OP_ADD, 8'hFF, 8'h01);
        tick();
        apply_stimulus(1'b0, OP_ADD, 8'h00, 8'h00);
        check_output("add_valid", {15'd0, out_valid}, 16'd1);
        check_output("add_out", {out_hi, out}, 16'h0000);
        check_flags("add_flags", 5'b11000);
        tick();
        check_output("add_drain", {15'd0, out_valid}, 16'd0);

        // SUB 80-01 then NAND back-to-back with no bubble.
        apply_stimulus(1'b1, OP_SUB, 8'h80, 8'h01);
        tick();
        check_output("sub_out", {out_hi, out}, 16'h007F);
        check_flags("sub_flags", 5'b01010);
        apply_stimulus(1'b1, OP_NAND, 8'hF0, 8'hFF);
        check_output("b2b_in_ready", {15'd0, in_ready}, 16'd1);
        tick();
        check_output("nand_valid", {15'd0, out_valid}, 16'd1);
        check_output("nand_out", {out_hi, out}, 16'h000F);
        check_flags("nand_flags", 5'b00000);

        // NOR and SHR chained back-to-back.
        apply_stimulus(1'b1, OP_NOR, 8'h0F, 8'hF0);
        tick();
        check_output("nor_out", {out_hi, out}, 16'h0000);
        check_flags("nor_flags", 5'b10000);
        apply_stimulus(1'b1, OP_SHR, 8'h81, 8'h00);
        tick();
        check_output("shr_out", {out_hi, out}, 16'h0040);
        check_flags("shr_flags", 5'b01000);
        apply_stimulus(1'b0, OP_SHR, 8'h00, 8'h00);
        tick();

        // Backpressure: XOR held for 5 cycles while new offers are refused.
        out_ready = 1'b0;
        apply_stimulus(1'b1, OP_XOR, 8'hAA, 8'h55);
        tick();
        apply_stimulus(1'b1, OP_ADD, 8'h01, 8'h01);
        for (int i = 0; i < 5; i++) begin
            check_output("bp_valid", {15'd0, out_valid}, 16'd1);
            check_output("bp_in_ready", {15'd0, in_ready}, 16'd0);
            check_output("bp_out", {out_hi, out}, 16'h00FF);
            check_flags("bp_flags", 5'b00100);
            tick();
        end
        apply_stimulus(1'b0, OP_ADD, 8'h00, 8'h00);
        out_ready = 1'b1;
        tick();
        check_output("bp_release_valid", {15'd0, out_valid}, 16'd0);
        check_output("bp_release_ready", {15'd0, in_ready}, 16'd1);

`ifdef ALU_MUL_EN
        // MUL 200*3 = 0x0258, with a competing offer held during BUSY.
        apply_stimulus(1'b1, OP_MUL, 8'd200, 8'd3);
        tick();
        apply_stimulus(1'b1, OP_ADD, 8'h01, 8'h01);
        for (int i = 0; i < 9; i++) begin
            check_output("mul_busy_ready", {15'd0, in_ready}, 16'd0);
            check_output("mul_busy_valid", {15'd0, out_valid}, 16'd0);
            tick();
        end
        check_output("mul_valid", {15'd0, out_valid}, 16'd1);
        check_output("mul_out", {out_hi, out}, 16'h0258);
        check_flags("mul_flags", 5'b00000);
        apply_stimulus(1'b0, OP_ADD, 8'h00, 8'h00);
        tick();
        check_output("mul_drain", {15'd0, out_valid}, 16'd0);

        // Reset in the middle of a multiply.
        apply_stimulus(1'b1, OP_MUL, 8'd200, 8'd3);
        tick();
        apply_stimulus(1'b0, OP_ADD, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
`else
        // Illegal opcode 111 in a build without the multiplier.
        apply_stimulus(1'b1, OP_MUL, 8'h05, 8'h07);
        tick();
        check_output("ill_valid", {15'd0, out_valid}, 16'd1);
        check_output("ill_out", {out_hi, out}, 16'h0000);
        check_flags("ill_flags", 5'b10001);
        apply_stimulus(1'b0, OP_ADD, 8'h00, 8'h00);
        tick();

        // Hold a nonzero result in DONE so reset visibly clears it.
        out_ready = 1'b0;
        apply_stimulus(1'b1, OP_XOR, 8'hAA, 8'h55);
        tick();
        apply_stimulus(1'b0, OP_ADD, 8'h00, 8'h00);
`endif
        rst_n = 1'b0;
        #1;
        check_output("midrst_valid", {15'd0, out_valid}, 16'd0);
        check_output("midrst_in_ready", {15'd0, in_ready}, 16'd0);
        check_output("midrst_out", {out_hi, out}, 16'h0000);
        check_flags("midrst_flags", 5'b00000);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check_output("post_rst_ready", {15'd0, in_ready}, 16'd1);
        apply_stimulus(1'b1, OP_ADD, 8'h01, 8'h02);
        tick();
        check_output("post_rst_add", {out_hi, out}, 16'h0003);
        check_flags("post_rst_flags", 5'b00000);

        // SHL 81: MSB shifted out into carry.
        apply_stimulus(1'b1, OP_SHL, 8'h81, 8'h00);
        tick();
        check_output("shl_out", {out_hi, out}, 16'h0002);
        check_flags("shl_flags", 5'b01000);

        // ADD 7F+01: signed overflow into a negative result.
        apply_stimulus(1'b1, OP_ADD, 8'h7F, 8'h01);
        tick();
        check_output("addv_out", {out_hi, out}, 16'h0080);
        check_flags("addv_flags", 5'b00110);
        apply_stimulus(1'b0, OP_ADD, 8'h00, 8'h00);
        tick();
        check_output("final_idle", {15'd0, out_valid}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
